// File: rtl/stream_pkg.sv
// Shared definitions for the LED stream scheduler: FSM state encoding,
// launch-acceptance timeout and default pacing constants.
package stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_ACCEPT,
    ST_RUN,
    ST_ADVANCE
  } state_e;

  localparam int ACCEPT_TIMEOUT   = 3;
  localparam int TICK_DIV_DEFAULT = 50000000;
  localparam int SEG_LEDS         = 8;

endpackage

// File: rtl/stream_tick_gen.sv
// Step-tick divider: one registered pulse every DIV enabled clocks.
// The synchronous clear restarts the count from zero.
module stream_tick_gen
  import stream_pkg::*;
#(
  parameter int DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // The pulse is registered, so it is raised one cycle ahead of the count
  // reaching LAST and lines up with the cycle in which the count equals LAST.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      tick_d = (cnt_q == PRE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/stream_seq.sv
// Scheduler that launches NSEG LED stream segments one at a time, paces them
// with a shared step tick and counts passes. STREAM_SEQ_BOUNCE_EN selects ping-pong order.
module stream_seq
  import stream_pkg::*;
#(
  parameter int NSEG     = 4,
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int LOOPS_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LOOPS_W-1:0]      loop_req,
  input  logic [NSEG-1:0]         seg_idle,
  output logic [NSEG-1:0]         seg_go,
  output logic                    step_tick,
  output logic [$clog2(NSEG)-1:0] active_seg,
  output logic [LOOPS_W-1:0]      pass_cnt,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int            AW       = $clog2(NSEG);
  localparam int            TW       = $clog2(ACCEPT_TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_SEG = AW'(NSEG - 1);
  localparam logic [TW-1:0] ACC_MAX  = TW'(ACCEPT_TIMEOUT);

  state_e             state_q, state_d;
  logic               start_q;
  logic [LOOPS_W-1:0] loops_q, loops_d;
  logic [LOOPS_W-1:0] pass_q, pass_d;
  logic [AW-1:0]      act_q, act_d;
  logic [TW-1:0]      acc_q, acc_d;
  logic               err_q, err_d;
  logic [NSEG-1:0]    go_q, go_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               start_edge;
`ifdef STREAM_SEQ_BOUNCE_EN
  logic               dir_q, dir_d;
`endif

  always_comb begin
    state_d    = state_q;
    loops_d    = loops_q;
    pass_d     = pass_q;
    act_d      = act_q;
    acc_d      = acc_q;
    err_d      = err_q;
    go_d       = '0;
    done_d     = 1'b0;
    start_edge = start & ~start_q;
`ifdef STREAM_SEQ_BOUNCE_EN
    dir_d      = dir_q;
`endif
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_edge) begin
            loops_d = loop_req;
            pass_d  = '0;
            act_d   = '0;
            err_d   = 1'b0;
            state_d = ST_LAUNCH;
`ifdef STREAM_SEQ_BOUNCE_EN
            dir_d   = 1'b0;
`endif
          end
        end
        ST_LAUNCH: begin
          go_d    = NSEG'(1) << act_q;
          acc_d   = '0;
          state_d = ST_ACCEPT;
        end
        ST_ACCEPT: begin
          // A segment that never leaves idle is flagged and skipped.
          if (!seg_idle[act_q]) begin
            state_d = ST_RUN;
          end else if (acc_q == ACC_MAX) begin
            err_d   = 1'b1;
            state_d = ST_ADVANCE;
          end else begin
            acc_d = acc_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (seg_idle[act_q]) state_d = ST_ADVANCE;
        end
        ST_ADVANCE: begin
          state_d = ST_LAUNCH;
`ifdef STREAM_SEQ_BOUNCE_EN
          // Ping-pong: turn around at each end; a pass ends after segment 0
          // has run on the way back down.
          if (!dir_q) begin
            if (act_q != LAST_SEG) begin
              act_d = act_q + 1'b1;
            end else begin
              dir_d = 1'b1;
              act_d = act_q - 1'b1;
            end
          end else if (act_q != '0) begin
            act_d = act_q - 1'b1;
          end else begin
            pass_d = pass_q + 1'b1;
            dir_d  = 1'b0;
            act_d  = AW'(1);
            if ((loops_q != '0) && (pass_d == loops_q)) begin
              act_d   = '0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
`else
          if (act_q != LAST_SEG) begin
            act_d = act_q + 1'b1;
          end else begin
            pass_d = pass_q + 1'b1;
            act_d  = '0;
            if ((loops_q != '0) && (pass_d == loops_q)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // The start edge register resets high so a start held through reset is not a request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      start_q <= 1'b1;
      loops_q <= '0;
      pass_q  <= '0;
      act_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      go_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef STREAM_SEQ_BOUNCE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start;
      loops_q <= loops_d;
      pass_q  <= pass_d;
      act_q   <= act_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      go_q    <= go_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef STREAM_SEQ_BOUNCE_EN
      dir_q   <= dir_d;
`endif
    end
  end

  // Clearing on the next state keeps the count at zero throughout IDLE.
  stream_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (busy_q),
    .clr   (~busy_d),
    .tick  (step_tick)
  );

  assign seg_go     = go_q;
  assign active_seg = act_q;
  assign pass_cnt   = pass_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
